// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   fwd_sel_e   : E-stage operand source select (regfile / W result / M ALU result)
//   mdu_state_e : MDU handshake sequencer states
//   REG_ZERO    : architectural x0, never a hazard source nor forwarded
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } mdu_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/forwarding_unit.sv
// E-stage operand forwarding selects for both source operands.
//   rs1E, rs2E           : E-stage source registers
//   rdM, rdW             : M/W destination registers
//   regWriteM, regWriteW : M/W write enables
//   forwardAE, forwardBE : per-operand source select (M has priority over W)
module forwarding_unit
  import hazard_pkg::*;
(
  input  logic [4:0] rs1E,
  input  logic [4:0] rs2E,
  input  logic [4:0] rdM,
  input  logic [4:0] rdW,
  input  logic       regWriteM,
  input  logic       regWriteW,
  output fwd_sel_e   forwardAE,
  output fwd_sel_e   forwardBE
);

  logic m_valid;
  logic w_valid;

  // A writer with destination x0 never produces a forwardable value.
  assign m_valid = regWriteM & (rdM != REG_ZERO);
  assign w_valid = regWriteW & (rdW != REG_ZERO);

  always_comb begin
    // NOTE: every output gets a default before the if-chain so no path leaves it unassigned (no latch).
    forwardAE = FWD_RF;
    forwardBE = FWD_RF;

    // M holds the younger result, so it is checked first.
    if (m_valid && (rdM == rs1E))      forwardAE = FWD_M;
    else if (w_valid && (rdW == rs1E)) forwardAE = FWD_W;

    if (m_valid && (rdM == rs2E))      forwardBE = FWD_M;
    else if (w_valid && (rdW == rs2E)) forwardBE = FWD_W;
  end

endmodule

// File: rtl/hazard_controller.sv
// Central hazard and sequencing controller for the 5-stage RV32 pipeline.
// Produces stall (register enable = ~stall) and flush controls for the
// F/D/E/M/W pipeline registers, E-stage forwarding selects, the start/done
// handshake with the multi-cycle MDU, wrong-path fetch tracking across
// instruction-memory wait states, and saturating performance counters.
//
// Ports:
//   clk, reset                      : clock, asynchronous active-high reset
//   rs1D, rs2D                      : D-stage source registers
//   rs1E, rs2E, rdE                 : E-stage sources and destination
//   rdM, rdW, regWriteM, regWriteW  : M/W destinations and write enables
//   loadE, mduE                     : E-stage instruction is a load / MUL-DIV
//   mdu_done                        : MDU result ready pulse
//   memReqM, dmem_ready             : M-stage data access pending / completed
//   PCSrcE                          : taken branch/jump resolved in E
//   imem_ready                      : fetch data valid this cycle
//   stallF/D/E/M, flushD/E/M/W      : pipeline register controls
//   mdu_start                       : one-cycle MDU launch
//   forwardAE, forwardBE            : 00 regfile, 01 W result, 10 M ALU result
//   stall_cycles, redirect_count    : saturating perf counters
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           rs1D,
  input  logic [4:0]           rs2D,
  input  logic [4:0]           rs1E,
  input  logic [4:0]           rs2E,
  input  logic [4:0]           rdE,
  input  logic [4:0]           rdM,
  input  logic [4:0]           rdW,
  input  logic                 regWriteM,
  input  logic                 regWriteW,
  input  logic                 loadE,
  input  logic                 mduE,
  input  logic                 mdu_done,
  input  logic                 memReqM,
  input  logic                 dmem_ready,
  input  logic                 PCSrcE,
  input  logic                 imem_ready,
  output logic                 stallF,
  output logic                 stallD,
  output logic                 stallE,
  output logic                 stallM,
  output logic                 flushD,
  output logic                 flushE,
  output logic                 flushM,
  output logic                 flushW,
  output logic                 mdu_start,
  output logic [1:0]           forwardAE,
  output logic [1:0]           forwardBE,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output logic [CNT_WIDTH-1:0] redirect_count
);

  mdu_state_e state;
  logic       redir_pend;

  logic       mem_stall;
  logic       mdu_stall;
  logic       lw_stall;
  logic       redirect;

  fwd_sel_e   fwd_a;
  fwd_sel_e   fwd_b;

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  assign mem_stall = memReqM & ~dmem_ready;

  // In RUN an MDU op in E stalls for the launch cycle; in MDU_WAIT it stalls
  // until the done pulse, which lets E advance on that same cycle.
  assign mdu_stall = ((state == RUN) & mduE) | ((state == MDU_WAIT) & ~mdu_done);

  assign lw_stall  = loadE & (rdE != REG_ZERO) & ((rdE == rs1D) | (rdE == rs2D));

  // A branch resolved in a held E stage is not acted on until E moves.
  assign redirect  = PCSrcE & ~stallE;

  // ---------------------------------------------------------------------------
  // Stall and flush controls; each stall implies all younger stages stall.
  // ---------------------------------------------------------------------------
  assign stallM = mem_stall;
  assign stallE = mem_stall | mdu_stall;
  assign stallD = stallE | lw_stall;
  assign stallF = stallD | ~imem_ready;

  // Bubbles go into the stage just past the oldest stalled one. flushM is
  // masked by memStall because M itself is held then.
  assign flushW = mem_stall;
  assign flushM = mdu_stall & ~mem_stall;
  assign flushE = (lw_stall | redirect) & ~stallE;

  // D takes a bubble on a redirect, when fetch has nothing valid, or when the
  // returning fetch is a wrong-path leftover; never while D must hold.
  assign flushD = redirect | (~stallD & (~imem_ready | redir_pend));

  // A pending memory stall defers the launch so the MDU never starts on an
  // instruction that is still frozen behind M.
  assign mdu_start = (state == RUN) & mduE & ~mem_stall;

  // ---------------------------------------------------------------------------
  // MDU sequencer and wrong-path fetch tracking
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RUN;
      redir_pend <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      case (state)
        RUN:      if (mdu_start) state <= MDU_WAIT;
        MDU_WAIT: if (mdu_done)  state <= RUN;
        default:                 state <= RUN;
      endcase

      // The fetch in flight when a redirect happens during an imem wait is
      // wrong-path; it is dropped when it returns. A further redirect while
      // pending leaves the flag set.
      if (redirect & ~imem_ready)
        redir_pend <= 1'b1;
      else if (imem_ready & ~redirect)
        redir_pend <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating performance counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles   <= '0;
      redirect_count <= '0;
    end else begin
      if (stallF && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_WIDTH'(1);
      if (redirect && (redirect_count != '1))
        redirect_count <= redirect_count + CNT_WIDTH'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Forwarding
  // ---------------------------------------------------------------------------
  forwarding_unit u_forwarding_unit (
    .rs1E      (rs1E),
    .rs2E      (rs2E),
    .rdM       (rdM),
    .rdW       (rdW),
    .regWriteM (regWriteM),
    .regWriteW (regWriteW),
    .forwardAE (fwd_a),
    .forwardBE (fwd_b)
  );

  assign forwardAE = fwd_a;
  assign forwardBE = fwd_b;

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Central hazard and sequencing controller for the 5-stage RV32 pipeline. It produces the stall (register enable = ~stall) and flush controls for the F/D/E/M/W pipeline registers. It also generates operand-forwarding selects for the E stage and runs the start/done handshake with the multi-cycle MDU. It tracks wrong-path fetches still in flight across instruction-memory wait states, and keeps saturating stall/redirect performance counters.

## Interface
- CNT_WIDTH, 32, width of performance counters
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- rs1D, rs2D  in  5  D-stage source registers
- rs1E, rs2E, rdE  in  5  E-stage sources and destination
- rdM, rdW  in  5  M/W destinations
- regWriteM, regWriteW  in  1  M/W write enables
- loadE  in  1  E-stage instruction is a load
- mduE  in  1  E-stage instruction is a multi-cycle MUL/DIV
- mdu_done  in  1  MDU result ready (pulse)
- memReqM, dmem_ready  in  1  M-stage data access pending / completed
- PCSrcE  in  1  taken branch/jump resolved in E
- imem_ready  in  1  fetch data valid this cycle
- stallF, stallD, stallE, stallM  out  1  hold stage register
- flushD, flushE, flushM, flushW  out  1  load bubble into stage register
- mdu_start  out  1  one-cycle MDU launch
- forwardAE, forwardBE  out  2  operand select: 00 regfile, 01 W result, 10 M ALU result
- stall_cycles, redirect_count  out  CNT_WIDTH  perf counters

## Operation
- Definitions:
  - memStall = memReqM & ~dmem_ready.
  - mduStall = (state==RUN & mduE) | (state==MDU_WAIT & ~mdu_done).
  - lwStall = loadE & rdE!=0 & (rdE==rs1D | rdE==rs2D).
  - redirect = PCSrcE & ~stallE.
- Stalls:
  - stallM = memStall.
  - stallE = memStall | mduStall.
  - stallD = stallE | lwStall.
  - stallF = stallD | ~imem_ready.
- Flushes:
  - flushW = memStall.
  - flushM = mduStall & ~memStall.
  - flushE = (lwStall | redirect) & ~stallE.
  - flushD = redirect | (~stallD & (~imem_ready | redir_pend)). The decode register gives flush priority over enable, so flushD never asserts while a held D instruction must survive, except on a redirect.
- MDU FSM, states RUN and MDU_WAIT:
  - mdu_start = state==RUN & mduE & ~memStall. RUN→MDU_WAIT on mdu_start.
  - MDU_WAIT→RUN on mdu_done. On that cycle mduStall=0 and E advances.
  - mdu_done is ignored in RUN.
  - If memStall and mduE coincide in RUN, the memory stall wins and the start is deferred.
- redir_pend register:
  - Set on redirect & ~imem_ready. The in-flight fetch is wrong-path.
  - Cleared on imem_ready & ~redirect. That returning instruction is discarded by flushD.
  - A redirect while pending keeps it set.
- Forwarding, per operand:
  - 10 if regWriteM & rdM!=0 & rdM==rsxE.
  - else 01 if regWriteW & rdW!=0 & rdW==rsxE.
  - else 00.
  - M has priority over W. x0 is never forwarded.
- Counters (saturate at all-ones, never wrap):
  - stall_cycles += 1 each cycle stallF=1.
  - redirect_count += 1 each cycle redirect=1.

## Timing
- Reset values: state=RUN, redir_pend=0, counters=0.
- Outputs are combinational from inputs and state; with quiescent inputs during reset, all stall/flush/mdu_start = 0, forwards = 00, except stallF = ~imem_ready and flushD = ~imem_ready (flushD is deliberately asserted while fetch data is not valid).
- MDU handshake:
  - mdu_start pulses in cycle t.
  - mdu_done is accepted no earlier than t+1.
  - For done at t+k, stallE is high for cycles t..t+k-1 and the E instruction advances at the end of t+k (k+1 cycles in E).
- Load-use costs exactly one bubble. Redirect costs two bubbles (D, E), plus the imem wait cycles.
- Reset mid-MDU_WAIT returns to RUN. A fresh mdu_start is issued if mduE is high after reset.
- Redirect and lwStall in the same cycle: the redirect dominates and flushE is asserted once.

## Structure
- Package hazard_pkg:
  - fwd_sel_e enum: FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10.
  - mdu_state_e enum: RUN, MDU_WAIT.
  - REG_ZERO constant.
- Sub-module forwarding_unit: combinational and instantiated once, producing both operands. The FSM, redir_pend and counters stay in hazard_controller.

## Test plan
- Load-use: loadE=1, rdE=5, rs1D=5 → one cycle with stallF=stallD=flushE=1. With rdE=0, no stall.
- Forwarding: rdM=rdW=7, regWrite both set, rs1E=7 → forwardAE=10. regWriteM=0 → 01. rdM=rdW=0 → 00.
- MDU: mduE held, mdu_done pulses 4 cycles after mdu_start → mdu_start is exactly 1 cycle, stallE high 4 cycles, flushM high 4 cycles, return to RUN.
- Redirect with ~imem_ready: PCSrcE=1 while imem_ready=0 for 3 cycles → redir_pend set, flushD on the cycle imem_ready returns, redirect_count=1.
- memStall during MDU_WAIT: dmem_ready=0 for 2 cycles → stallM=flushW=1, flushM=0, and the state stays MDU_WAIT until mdu_done.
- Saturation and reset: CNT_WIDTH=4, 20 stalled cycles → stall_cycles=15. Assert reset mid-MDU_WAIT → state=RUN, counters=0.
